// File: rtl/numbotron_sequencer_if.sv
// numbotron_sequencer_if: program-load and register-file step bus.
// The instruction word widens by AW when NUMBOTRON_JUMP_EN is defined.
interface numbotron_sequencer_if #(
    parameter int NREGS = 8,
    parameter int AW    = 5
);
`ifdef NUMBOTRON_JUMP_EN
    localparam int IW = 3 * NREGS + AW;
`else
    localparam int IW = 3 * NREGS;
`endif
    logic             prog_we;
    logic [AW-1:0]    prog_addr;
    logic [IW-1:0]    prog_wdata;
    logic [NREGS-1:0] reg_zero;
    logic [NREGS-1:0] inc_regs;
    logic [NREGS-1:0] dec_regs;
    logic             dostep;

    modport master (output prog_we, prog_addr, prog_wdata, reg_zero,
                    input  inc_regs, dec_regs, dostep);
    modport slave  (input  prog_we, prog_addr, prog_wdata, reg_zero,
                    output inc_regs, dec_regs, dostep);
endinterface

// File: rtl/numbotron_sequencer.sv
// numbotron_sequencer: loop-until-zero instruction sequencer with writable program RAM.
// Define NUMBOTRON_JUMP_EN to make completion branch to the instruction's T field.
module numbotron_sequencer #(
    parameter int NREGS = 8,
    parameter int AW    = 5
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                slowclk,
    input  logic                step,
    input  logic                run_mode,
    input  logic                start,
    numbotron_sequencer_if.slave bus,
    output logic [AW-1:0]       ip,
    output logic                running,
    output logic                halted
);
`ifdef NUMBOTRON_JUMP_EN
    localparam int IW = 3 * NREGS + AW;
`else
    localparam int IW = 3 * NREGS;
`endif
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t           state, state_n;
    logic [IW-1:0]    mem [2**AW];
    logic [IW-1:0]    ir, ir_n, word;
    logic [AW-1:0]    ip_n, next_f, next_e;
    logic [NREGS-1:0] inc_n, dec_n;
    logic             dostep_n, halted_n, step_d, step_pend, tick, idle;

    assign idle = (state == IDLE) || (state == HALT);
    assign word = mem[ip];
    // A tick during dostep would see reg_zero before the register file updates
    assign tick = slowclk & (run_mode | step_pend) & ~bus.dostep;

`ifdef NUMBOTRON_JUMP_EN
    assign next_f = word[3*NREGS +: AW];
    assign next_e = ir[3*NREGS +: AW];
`else
    assign next_f = ip + AW'(1);
    assign next_e = ip + AW'(1);
`endif

    always_ff @(posedge clk)
        if (bus.prog_we && idle) mem[bus.prog_addr] <= bus.prog_wdata;

    always_ff @(posedge clk or negedge rstb)
        if (!rstb) begin
            step_d    <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            step_d    <= step;
            step_pend <= ~idle & ((step_pend & ~tick) | (step & ~step_d & ~run_mode));
        end

    always_comb begin
        state_n  = state;
        ip_n     = ip;
        ir_n     = ir;
        halted_n = halted;
        dostep_n = 1'b0;
        inc_n    = '0;
        dec_n    = '0;
        if (idle) begin
            if (start) begin
                state_n  = FETCH;
                ip_n     = '0;
                halted_n = 1'b0;
            end
        end else if (tick) begin
            if (state == FETCH) begin
                ir_n = word;
                if (word[NREGS-1:0] == '0) begin
                    state_n  = HALT;
                    halted_n = 1'b1;
                end else if (|(word[NREGS-1:0] & bus.reg_zero)) begin
                    ip_n = next_f;
                end else begin
                    state_n  = EXEC;
                    dostep_n = 1'b1;
                    dec_n    = word[2*NREGS-1:NREGS];
                    inc_n    = word[3*NREGS-1:2*NREGS];
                end
            end else if (|(ir[NREGS-1:0] & bus.reg_zero)) begin
                state_n = FETCH;
                ip_n    = next_e;
            end else begin
                dostep_n = 1'b1;
                dec_n    = ir[2*NREGS-1:NREGS];
                inc_n    = ir[3*NREGS-1:2*NREGS];
            end
        end
    end

    always_ff @(posedge clk or negedge rstb)
        if (!rstb) begin
            state        <= IDLE;
            ip           <= '0;
            ir           <= '0;
            halted       <= 1'b0;
            running      <= 1'b0;
            bus.dostep   <= 1'b0;
            bus.inc_regs <= '0;
            bus.dec_regs <= '0;
        end else begin
            state        <= state_n;
            ip           <= ip_n;
            ir           <= ir_n;
            halted       <= halted_n;
            running      <= (state_n == FETCH) || (state_n == EXEC);
            bus.dostep   <= dostep_n;
            bus.inc_regs <= inc_n;
            bus.dec_regs <= dec_n;
        end
endmodule

// File: tb/tb_numbotron_sequencer.sv
// tb_numbotron_sequencer: directed bench with a small counter register-file model.
module tb_numbotron_sequencer;
    localparam int N  = 8;
    localparam int AW = 5;
`ifdef NUMBOTRON_JUMP_EN
    localparam int IW = 3 * N + AW;
`else
    localparam int IW = 3 * N;
`endif

    logic clk = 1'b0, rstb = 1'b1, slowclk = 1'b0, step = 1'b0, run_mode = 1'b1, start = 1'b0;
    logic [AW-1:0] ip;
    logic          running, halted;
    logic [7:0]    regs [N];
    logic [N-1:0]  rz;
    logic          ds;
    logic [N-1:0]  inc_s, dec_s;
    int            pulses = 0, vectors = 0, errors = 0, p0 = 0;

    numbotron_sequencer_if #(.NREGS(N), .AW(AW)) bus ();

    numbotron_sequencer #(.NREGS(N), .AW(AW)) dut (
        .clk(clk), .rstb(rstb), .slowclk(slowclk), .step(step), .run_mode(run_mode),
        .start(start), .bus(bus), .ip(ip), .running(running), .halted(halted)
    );

    always #5 clk = ~clk;

    always_comb for (int i = 0; i < N; i++) rz[i] = (regs[i] == 8'd0);
    assign bus.reg_zero = rz;

    // register file applies a step on the edge that ends dostep
    always @(posedge clk) begin : rf
        logic d;
        logic [N-1:0] a, s;
        d = bus.dostep;
        a = bus.inc_regs;
        s = bus.dec_regs;
        #1;
        if (d) begin
            pulses++;
            for (int i = 0; i < N; i++) regs[i] = regs[i] + 8'(a[i]) - 8'(s[i]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic [AW-1:0] t, input logic [N-1:0] z, d, i);
        return IW'({t, i, d, z});
    endfunction

    task automatic wr(input int a, input logic [IW-1:0] w);
        bus.prog_we = 1'b1;
        bus.prog_addr = AW'(a);
        bus.prog_wdata = w;
        @(negedge clk);
        bus.prog_we = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic tick;
        slowclk = 1'b1;
        @(negedge clk);
        ds = bus.dostep;
        inc_s = bus.inc_regs;
        dec_s = bus.dec_regs;
        slowclk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.prog_we = 1'b0;
        bus.prog_addr = '0;
        bus.prog_wdata = '0;
        for (int i = 0; i < N; i++) regs[i] = 8'd9;
        #2 rstb = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ip", 32'(ip), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_dostep", 32'(bus.dostep), 0);
        chk("rst_inc", 32'(bus.inc_regs), 0);
        chk("rst_dec", 32'(bus.dec_regs), 0);
        rstb = 1'b1;
        @(negedge clk);

        // move loop: reg0 -> reg1, three steps, then halt at ip 1
        wr(0, mk(1, 8'h01, 8'h01, 8'h02));
        wr(1, mk(2, 8'h00, 8'h00, 8'h00));
        regs[0] = 8'd3;
        regs[1] = 8'd0;
        p0 = pulses;
        pulse_start;
        chk("start_running", 32'(running), 1);
        chk("start_ip", 32'(ip), 0);
        tick;
        chk("move_ds1", 32'(ds), 1);
        chk("move_dec", 32'(dec_s), 32'h01);
        chk("move_inc", 32'(inc_s), 32'h02);
        chk("mask_zero_idle", 32'(bus.dec_regs), 0);
        tick;
        chk("move_ds2", 32'(ds), 1);
        tick;
        chk("move_ds3", 32'(ds), 1);
        chk("move_reg0", 32'(regs[0]), 0);
        chk("move_reg1", 32'(regs[1]), 3);
        tick;
        chk("move_done_ds", 32'(ds), 0);
        chk("move_ip", 32'(ip), 1);
        tick;
        chk("move_halted", 32'(halted), 1);
        chk("move_not_running", 32'(running), 0);
        chk("move_pulses", 32'(pulses - p0), 3);

        // zero already true: one tick, no step
        wr(0, mk(1, 8'h04, 8'h01, 8'h02));
        regs[2] = 8'd0;
        pulse_start;
        chk("restart_halted_clr", 32'(halted), 0);
        tick;
        chk("zero_no_ds", 32'(ds), 0);
        chk("zero_ip", 32'(ip), 1);
        tick;
        chk("zero_halted", 32'(halted), 1);

        // single step: held button gives one tick
        wr(0, mk(1, 8'h01, 8'h01, 8'h02));
        regs[0] = 8'd5;
        run_mode = 1'b0;
        pulse_start;
        p0 = pulses;
        step = 1'b1;
        repeat (5) tick;
        chk("step_held_once", 32'(pulses - p0), 1);
        chk("step_ip", 32'(ip), 0);
        chk("step_running", 32'(running), 1);
        step = 1'b0;
        @(negedge clk);
        step = 1'b1;
        tick;
        tick;
        chk("step_second", 32'(pulses - p0), 2);
        step = 1'b0;

        // program write while running must be dropped
        wr(1, mk(2, 8'h01, 8'h00, 8'h00));

        // stale-flag guard: second slowclk cycle lands on dostep
        regs[0] = 8'd1;
        run_mode = 1'b1;
        p0 = pulses;
        slowclk = 1'b1;
        @(negedge clk);
        chk("stale_ds_first", 32'(bus.dostep), 1);
        @(negedge clk);
        slowclk = 1'b0;
        chk("stale_ignored", 32'(bus.dostep), 0);
        repeat (3) @(negedge clk);
        chk("stale_pulses", 32'(pulses - p0), 1);
        chk("stale_reg0", 32'(regs[0]), 0);
        tick;
        chk("stale_next_ds", 32'(ds), 0);
        chk("stale_next_ip", 32'(ip), 1);
        tick;
        chk("we_ignored_halt", 32'(halted), 1);

        // asynchronous reset mid-EXEC at ip 1
        wr(0, mk(1, 8'h04, 8'h00, 8'h00));
        wr(1, mk(2, 8'h01, 8'h01, 8'h02));
        regs[0] = 8'd3;
        regs[2] = 8'd0;
        pulse_start;
        tick;
        chk("pre_rst_ip", 32'(ip), 1);
        slowclk = 1'b1;
        @(negedge clk);
        slowclk = 1'b0;
        chk("pre_rst_ds", 32'(bus.dostep), 1);
        #2 rstb = 1'b0;
        #1;
        chk("async_ds", 32'(bus.dostep), 0);
        chk("async_dec", 32'(bus.dec_regs), 0);
        chk("async_inc", 32'(bus.inc_regs), 0);
        chk("async_ip", 32'(ip), 0);
        chk("async_running", 32'(running), 0);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        pulse_start;
        tick;
        chk("ram_kept_ip", 32'(ip), 1);
        tick;
        chk("ram_kept_ds", 32'(ds), 1);
        chk("ram_kept_dec", 32'(dec_s), 32'h01);
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);

        // wrap (or jump to 7) from the last address
        regs[0] = 8'd0;
        for (int k = 0; k < 32; k++) wr(k, mk(AW'(k == 31 ? 7 : k + 1), 8'h01, 8'h00, 8'h00));
        p0 = pulses;
        pulse_start;
        repeat (31) tick;
        chk("wrap_ip31", 32'(ip), 31);
        tick;
`ifdef NUMBOTRON_JUMP_EN
        chk("jump_ip", 32'(ip), 7);
`else
        chk("wrap_ip", 32'(ip), 0);
`endif
        chk("wrap_running", 32'(running), 1);
        chk("wrap_no_pulses", 32'(pulses - p0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
